// File: rtl/knn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : knn_ctrl_if
// Description : Training-memory read port and sorter insert stream of knn_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface knn_ctrl_if #(
    parameter int COORD_W = 16,
    parameter int N_W     = 8
);
    localparam int DIST_W = 2 * COORD_W + 2;

    logic                      mem_en;
    logic [N_W-1:0]            mem_addr;
    logic signed [COORD_W-1:0] mem_x;
    logic signed [COORD_W-1:0] mem_y;

    logic                      out_valid;
    logic                      out_ready;
    logic [DIST_W-1:0]         out_dist;
    logic [N_W-1:0]            out_idx;
    logic                      out_last;

    modport master (
        output mem_en, mem_addr,
        input  mem_x, mem_y,
        output out_valid, out_dist, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_en, mem_addr,
        output mem_x, mem_y,
        input  out_valid, out_dist, out_idx, out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/knn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : knn_ctrl
// Description : Walks the training memory, computes squared distances to a
//               latched test point and streams (distance, index) inserts.
// Revision    : 1.0 - initial release
// ============================================================================
module knn_ctrl #(
    parameter int COORD_W = 16,
    parameter int N_W     = 8
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      start,
    input  wire logic [N_W-1:0]            n_points,
    input  wire logic signed [COORD_W-1:0] test_x,
    input  wire logic signed [COORD_W-1:0] test_y,
    knn_ctrl_if.master                     bus,
    output logic                           busy,
    output logic                           done,
    output logic [N_W-1:0]                 count
);
    localparam int DIST_W = 2 * COORD_W + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_CALC  = 3'd3,
        S_SEND  = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [N_W-1:0]            r_n;
    logic [N_W-1:0]            r_idx;
    logic [N_W-1:0]            r_count;
    logic signed [COORD_W-1:0] r_tx;
    logic signed [COORD_W-1:0] r_ty;
    logic signed [COORD_W-1:0] r_mx;
    logic signed [COORD_W-1:0] r_my;
    logic [DIST_W-1:0]         r_dist;
    logic                      r_done;

    logic                      w_is_last;
    logic                      w_hs;
    logic signed [COORD_W:0]   w_dx;
    logic signed [COORD_W:0]   w_dy;
    logic signed [DIST_W-1:0]  w_dx_ext;
    logic signed [DIST_W-1:0]  w_dy_ext;
    logic signed [DIST_W-1:0]  w_dx2;
    logic signed [DIST_W-1:0]  w_dy2;
    logic [DIST_W-1:0]         w_dist;

    // Differences are exact in COORD_W+1 bits; squaring at DIST_W keeps the sum exact.
    assign w_dx     = {r_mx[COORD_W-1], r_mx} - {r_tx[COORD_W-1], r_tx};
    assign w_dy     = {r_my[COORD_W-1], r_my} - {r_ty[COORD_W-1], r_ty};
    assign w_dx_ext = DIST_W'(w_dx);
    assign w_dy_ext = DIST_W'(w_dy);
    assign w_dx2    = w_dx_ext * w_dx_ext;
    assign w_dy2    = w_dy_ext * w_dy_ext;
    assign w_dist   = $unsigned(w_dx2) + $unsigned(w_dy2);

    assign w_is_last = (r_idx == (r_n - N_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_hs        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (n_points != '0)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_SEND;
            S_SEND: begin
                w_hs = bus.out_ready;
                if (bus.out_ready) begin
                    w_state_nxt = w_is_last ? S_IDLE : S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n     <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_tx    <= '0;
            r_ty    <= '0;
            r_mx    <= '0;
            r_my    <= '0;
            r_dist  <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n     <= n_points;
                        r_tx    <= test_x;
                        r_ty    <= test_y;
                        r_idx   <= '0;
                        r_count <= '0;
                        r_done  <= (n_points == '0);
                    end
                end
                S_LOAD: begin
                    r_mx <= bus.mem_x;
                    r_my <= bus.mem_y;
                end
                S_CALC: r_dist <= w_dist;
                S_SEND: begin
                    if (w_hs) begin
                        r_count <= r_count + N_W'(1);
                        if (w_is_last) begin
                            r_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + N_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = (r_state == S_FETCH);
    assign bus.mem_addr  = (r_state == S_FETCH) ? r_idx : '0;
    assign bus.out_valid = (r_state == S_SEND);
    assign bus.out_dist  = r_dist;
    assign bus.out_idx   = (r_state == S_SEND) ? r_idx : '0;
    assign bus.out_last  = (r_state == S_SEND) && w_is_last;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_knn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_knn_ctrl
// Description : Self-checking bench for knn_ctrl against a distance/queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_ctrl;
    localparam int COORD_W = 16;
    localparam int N_W     = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [N_W-1:0]     n_points;
    logic signed [15:0] test_x;
    logic signed [15:0] test_y;
    logic               busy;
    logic               done;
    logic [N_W-1:0]     count;

    knn_ctrl_if #(.COORD_W(COORD_W), .N_W(N_W)) bus ();

    knn_ctrl #(.COORD_W(COORD_W), .N_W(N_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_points (n_points),
        .test_x   (test_x),
        .test_y   (test_y),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    logic signed [15:0] mx [256];
    logic signed [15:0] my [256];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_x <= mx[bus.mem_addr];
            bus.mem_y <= my[bus.mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_dist(input int x, input int y, input int tx, input int ty);
        longint dx;
        longint dy;
        dx = longint'(x) - longint'(tx);
        dy = longint'(y) - longint'(ty);
        return 64'(dx * dx + dy * dy);
    endfunction

    // Sorter model: drives out_ready, records handshakes, watches stall behaviour.
    int          ready_mode   = 0;
    int          stall_cnt    = 0;
    int          stall_cycles = 0;
    int          mem_reads    = 0;
    logic [63:0] hs_dist [$];
    int          hs_idx  [$];
    int          hs_last [$];
    int          hs_cyc  [$];
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic [33:0] p_dist;
    logic [7:0]  p_idx;
    logic        p_last;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            bus.out_ready = 1'b0;
            p_valid       = 1'b0;
            stall_cnt     = 0;
        end else begin
            if (bus.mem_en) mem_reads++;
            if (bus.out_valid) chk("no_read_in_send", {63'd0, bus.mem_en}, 64'd0);
            if (p_valid && !p_ready) begin
                chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
                chk("hold_dist", {30'd0, bus.out_dist}, {30'd0, p_dist});
                chk("hold_idx", {56'd0, bus.out_idx}, {56'd0, p_idx});
                chk("hold_last", {63'd0, bus.out_last}, {63'd0, p_last});
            end
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (bus.out_valid && stall_cnt < 3) begin
                        bus.out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        bus.out_ready = 1'b1;
                        stall_cnt     = 0;
                    end
                end
                default: bus.out_ready = 1'b0;
            endcase
            if (bus.out_valid && !bus.out_ready) stall_cycles++;
            if (bus.out_valid && bus.out_ready) begin
                hs_dist.push_back({30'd0, bus.out_dist});
                hs_idx.push_back(int'(bus.out_idx));
                hs_last.push_back(int'(bus.out_last));
                hs_cyc.push_back(cyc + 1);
            end
            p_valid = bus.out_valid;
            p_ready = bus.out_ready;
            p_dist  = bus.out_dist;
            p_idx   = bus.out_idx;
            p_last  = bus.out_last;
        end
    end

    int start_cyc  = 0;
    int mem_reads0 = 0;

    task automatic do_start(input int n, input int tx, input int ty);
        hs_dist.delete();
        hs_idx.delete();
        hs_last.delete();
        hs_cyc.delete();
        @(negedge clk);
        mem_reads0 = mem_reads;
        start      = 1'b1;
        n_points   = N_W'(n);
        test_x     = 16'(tx);
        test_y     = 16'(ty);
        start_cyc  = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input int n, input int tx, input int ty, input string tag);
        int m;
        for (int k = 0; k < 3000 && hs_dist.size() < n; k++) @(negedge clk);
        chk({tag, "_handshakes"}, 64'(hs_dist.size()), 64'(n));
        chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done_end"}, {63'd0, done}, 64'd1);
        chk({tag, "_count_end"}, {56'd0, count}, 64'(n));
        chk({tag, "_mem_reads"}, 64'(mem_reads - mem_reads0), 64'(n));
        m = (hs_dist.size() < n) ? hs_dist.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_dist%0d", tag, i), hs_dist[i], ref_dist(mx[i], my[i], tx, ty));
            chk($sformatf("%s_idx%0d", tag, i), 64'(hs_idx[i]), 64'(i));
            chk($sformatf("%s_last%0d", tag, i), 64'(hs_last[i]), 64'((i == n - 1) ? 1 : 0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_en"}, {63'd0, bus.mem_en}, 64'd0);
        chk({tag, "_mem_addr"}, {56'd0, bus.mem_addr}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_out_dist"}, {30'd0, bus.out_dist}, 64'd0);
        chk({tag, "_out_idx"}, {56'd0, bus.out_idx}, 64'd0);
        chk({tag, "_out_last"}, {63'd0, bus.out_last}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_count"}, {56'd0, count}, 64'd0);
    endtask

    initial begin
        int tx;
        int ty;
        int n;
        int rc;

        rst      = 1'b1;
        start    = 1'b0;
        n_points = '0;
        test_x   = '0;
        test_y   = '0;
        for (int i = 0; i < 256; i++) begin
            mx[i] = 16'($urandom);
            my[i] = 16'($urandom);
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic run with exact timing
        mx[0] = 16'sd0; my[0] = 16'sd0;
        mx[1] = 16'sd3; my[1] = 16'sd4;
        mx[2] = 16'sd6; my[2] = 16'sd8;
        ready_mode = 0;
        do_start(3, 3, 4);
        chk("basic_first_mem_en", {63'd0, bus.mem_en}, 64'd1);
        chk("basic_first_addr", {56'd0, bus.mem_addr}, 64'd0);
        chk("basic_first_busy", {63'd0, busy}, 64'd1);
        chk("basic_first_done", {63'd0, done}, 64'd0);
        finish_run(3, 3, 4, "basic");
        if (hs_dist.size() == 3) begin
            chk("basic_d0", hs_dist[0], 64'd25);
            chk("basic_d1", hs_dist[1], 64'd0);
            chk("basic_d2", hs_dist[2], 64'd25);
            chk("basic_latency", 64'(hs_cyc[2] - start_cyc), 64'd12);
        end

        // Extreme coordinates
        mx[0] = -16'sd32768; my[0] = -16'sd32768;
        do_start(1, 32767, 32767);
        finish_run(1, 32767, 32767, "extreme");
        if (hs_dist.size() == 1) chk("extreme_exact", hs_dist[0], 64'd8589672450);

        // Backpressure: three stall cycles in each SEND
        mx[0] = 16'sd100;  my[0] = -16'sd7;
        mx[1] = -16'sd900; my[1] = 16'sd1234;
        ready_mode   = 2;
        stall_cycles = 0;
        do_start(2, -50, 60);
        finish_run(2, -50, 60, "bp");
        chk("bp_stall_cycles", 64'(stall_cycles), 64'd6);

        // Zero points
        ready_mode = 0;
        do_start(0, 1, 1);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_busy", {63'd0, busy}, 64'd0);
        chk("zero_mem_en", {63'd0, bus.mem_en}, 64'd0);
        chk("zero_valid", {63'd0, bus.out_valid}, 64'd0);
        repeat (6) @(negedge clk);
        chk("zero_no_reads", 64'(mem_reads - mem_reads0), 64'd0);
        chk("zero_no_inserts", 64'(hs_dist.size()), 64'd0);
        chk("zero_count", {56'd0, count}, 64'd0);
        chk("zero_done_sticky", {63'd0, done}, 64'd1);

        // Start while busy is ignored
        for (int i = 0; i < 4; i++) begin
            mx[i] = 16'($urandom);
            my[i] = 16'($urandom);
        end
        tx = int'($signed(16'($urandom)));
        ty = int'($signed(16'($urandom)));
        do_start(4, tx, ty);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        n_points = 8'd7;
        test_x   = 16'(tx + 1000);
        test_y   = 16'(ty - 333);
        @(negedge clk);
        start = 1'b0;
        finish_run(4, tx, ty, "busy_start");
        repeat (8) @(negedge clk);
        chk("busy_start_no_extra", 64'(hs_dist.size()), 64'd4);

        // Randomized runs with random backpressure
        for (int r = 0; r < 5; r++) begin
            n = int'($urandom_range(1, 10));
            for (int i = 0; i < n; i++) begin
                mx[i] = 16'($urandom);
                my[i] = 16'($urandom);
            end
            tx = int'($signed(16'($urandom)));
            ty = int'($signed(16'($urandom)));
            ready_mode = 1;
            do_start(n, tx, ty);
            finish_run(n, tx, ty, $sformatf("rand%0d", r));
        end

        // Reset while stalled in SEND, then a fresh run
        ready_mode = 3;
        do_start(2, 5, -5);
        rc = 0;
        for (int k = 0; k < 50 && !bus.out_valid; k++) begin
            @(negedge clk);
            rc++;
        end
        chk("rst_reach_send", {63'd0, bus.out_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        ready_mode = 0;
        mx[0] = 16'sd10; my[0] = 16'sd20;
        mx[1] = -16'sd30; my[1] = 16'sd40;
        do_start(2, 1, 2);
        finish_run(2, 1, 2, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
